// File: rtl/pipeline_mem_arbiter.sv
// Purpose: shares the single physical-memory line port between the I-cache and D-cache; D has priority, with a streak cap so I is not starved.
// Latency: a request seen in IDLE is granted at that edge; resp pulses the cycle after pmem_resp (minimum 2 cycles request-to-resp).
// Backpressure: none. Caches hold their request until their resp pulse; the losing side waits in IDLE, and pmem strobes hold until pmem_resp.
module pipeline_mem_arbiter #(
   parameter int LINE_W       = 128,
   parameter int ADDR_W       = 16,
   parameter int MAX_D_STREAK = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_read,
   input  logic [ADDR_W-1:0] icache_address,
   output logic              icache_resp,
   output logic [LINE_W-1:0] icache_rdata,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [ADDR_W-1:0] dcache_address,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic              dcache_resp,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              arb_busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

   logic [1:0]        state;
   logic              owner;      // 0 = I side, 1 = D side
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] line_q;
   logic [2:0]        d_streak;

   logic d_req;
   logic i_req;
   logic grant_d;
   logic grant_i;
   logic serving;

   // D wins unless I is also waiting and D has already used up its streak.
   assign d_req   = dcache_read | dcache_write;
   assign i_req   = icache_read;
   assign grant_d = d_req & ~(i_req & (d_streak == STREAK_MAX));
   assign grant_i = i_req & ~grant_d;

   // Grant, latch the request, wait for memory, then hold the line for one resp cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         op_write <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         line_q   <= '0;
         d_streak <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state    <= SERVE_D;
                  owner    <= 1'b1;
                  // read+write together is treated as a write
                  op_write <= dcache_write;
                  addr_q   <= dcache_address;
                  if (dcache_write) begin
                     wdata_q <= dcache_wdata;
                  end
                  // only contested D grants count toward the streak
                  if (i_req && (d_streak != STREAK_MAX)) begin
                     d_streak <= d_streak + 3'd1;
                  end
               end else if (grant_i) begin
                  state    <= SERVE_I;
                  owner    <= 1'b0;
                  op_write <= 1'b0;
                  addr_q   <= icache_address;
                  d_streak <= '0;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  line_q <= pmem_rdata;
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from state so an async reset drops them immediately.
   assign serving      = (state == SERVE_I) || (state == SERVE_D);
   assign pmem_read    = serving & ~op_write;
   assign pmem_write   = serving & op_write;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   assign icache_resp  = (state == DONE) & ~owner;
   assign dcache_resp  = (state == DONE) & owner;
   assign icache_rdata = line_q;
   assign dcache_rdata = line_q;
   assign arb_busy     = (state != IDLE);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;

   typedef struct packed {
      logic         side;   // 0 = I, 1 = D
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         icache_read = 1'b0;
   logic [15:0]  icache_address = '0;
   logic         icache_resp;
   logic [127:0] icache_rdata;
   logic         dcache_read = 1'b0;
   logic         dcache_write = 1'b0;
   logic [15:0]  dcache_address = '0;
   logic [127:0] dcache_wdata = '0;
   logic         dcache_resp;
   logic [127:0] dcache_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp;
   logic         arb_busy;

   logic         mem_resp = 1'b0;
   logic         inj_resp = 1'b0;
   int           mem_lat = 2;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           rd_cycles = 0;
   int           wr_cycles = 0;
   logic         chk_en = 1'b0;
   logic [15:0]  exp_addr = '0;
   logic [127:0] exp_wdata = '0;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] PAT_5A = {16{8'h5A}};
   localparam logic [127:0] PAT_11 = {16{8'h11}};

   assign pmem_resp = mem_resp | inj_resp;

   pipeline_mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_resp    (icache_resp),
      .icache_rdata   (icache_rdata),
      .dcache_read    (dcache_read),
      .dcache_write   (dcache_write),
      .dcache_address (dcache_address),
      .dcache_wdata   (dcache_wdata),
      .dcache_resp    (dcache_resp),
      .dcache_rdata   (dcache_rdata),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .arb_busy       (arb_busy)
   );

   always #5 clk = ~clk;

   // Memory contents: a line is a fixed pattern of its address.
   function automatic logic [127:0] line_of(input logic [15:0] a);
      return {4{a, ~a}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic side, input logic [15:0] a);
      exp_t e;
      e.side = side;
      e.data = line_of(a);
      sb.push_back(e);
   endtask

   task automatic wait_resp(input int budget, output logic side);
      side = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (icache_resp || dcache_resp) begin
            side = dcache_resp;
            return;
         end
      end
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got no resp within %0d cycles", budget);
   endtask

   // Memory model: responds on the mem_lat-th cycle a strobe has been high.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if ((pmem_read || pmem_write) && rst_n) begin
            cnt++;
            if (cnt == mem_lat) begin
               mem_resp   = 1'b1;
               pmem_rdata = line_of(pmem_address);
               cnt        = 0;
            end else begin
               mem_resp = 1'b0;
            end
         end else begin
            mem_resp = 1'b0;
            cnt      = 0;
         end
      end
   end

   // Monitor: strobe accounting, address/wdata stability, scoreboard pops on resp.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pmem_read) rd_cycles++;
         if (pmem_write) wr_cycles++;
         if (chk_en && (pmem_read || pmem_write)) begin
            check("pmem_address", 128'(pmem_address), 128'(exp_addr));
            if (pmem_write) check("pmem_wdata", pmem_wdata, exp_wdata);
         end
         if (icache_resp || dcache_resp) begin
            check("resp_exclusive", 128'(icache_resp & dcache_resp), 128'(0));
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_resp: got i=%0b d=%0b expected none", icache_resp, dcache_resp);
            end else begin
               e = sb.pop_front();
               check("resp_side", 128'(dcache_resp), 128'(e.side));
               check("resp_rdata", e.side ? dcache_rdata : icache_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic side;
      logic pat [11];
      int   dk;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

      // reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_icache_resp", 128'(icache_resp), 128'(0));
      check("rst_dcache_resp", 128'(dcache_resp), 128'(0));
      check("rst_pmem_read", 128'(pmem_read), 128'(0));
      check("rst_pmem_write", 128'(pmem_write), 128'(0));
      check("rst_arb_busy", 128'(arb_busy), 128'(0));
      check("rst_pmem_address", 128'(pmem_address), 128'(0));
      check("rst_pmem_wdata", pmem_wdata, 128'(0));
      check("rst_rdata", icache_rdata, 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // stray pmem_resp while idle
      @(posedge clk); #1 inj_resp = 1'b1;
      @(negedge clk);
      check("idle_resp_busy", 128'(arb_busy), 128'(0));
      @(posedge clk); #1 inj_resp = 1'b0;
      @(negedge clk);
      check("idle_resp_busy2", 128'(arb_busy), 128'(0));
      check("idle_resp_out", 128'({icache_resp, dcache_resp}), 128'(0));

      // I-only fill, memory answers on the 3rd strobe cycle
      chk_en = 1'b1; exp_addr = 16'h1230; mem_lat = 3;
      rd_cycles = 0; wr_cycles = 0;
      push(1'b0, 16'h1230);
      @(posedge clk); #1 icache_read = 1'b1; icache_address = 16'h1230;
      wait_resp(20, side);
      @(posedge clk); #1 icache_read = 1'b0;
      check("ifill_rd_cycles", 128'(rd_cycles), 128'(3));
      check("ifill_wr_cycles", 128'(wr_cycles), 128'(0));

      // D writeback, inputs change mid-transfer
      exp_addr = 16'h3000; exp_wdata = PAT_A5; mem_lat = 4;
      rd_cycles = 0; wr_cycles = 0;
      push(1'b1, 16'h3000);
      @(posedge clk); #1 dcache_write = 1'b1; dcache_address = 16'h3000; dcache_wdata = PAT_A5;
      repeat (3) @(posedge clk);
      #1 dcache_wdata = PAT_5A; dcache_address = 16'h3F00;
      wait_resp(20, side);
      @(posedge clk); #1 dcache_write = 1'b0;
      check("dwb_wr_cycles", 128'(wr_cycles), 128'(4));
      check("dwb_rd_cycles", 128'(rd_cycles), 128'(0));

      // read and write together behaves as a write
      exp_addr = 16'h3100; exp_wdata = PAT_11; mem_lat = 2;
      rd_cycles = 0; wr_cycles = 0;
      push(1'b1, 16'h3100);
      @(posedge clk); #1 dcache_read = 1'b1; dcache_write = 1'b1;
      dcache_address = 16'h3100; dcache_wdata = PAT_11;
      wait_resp(20, side);
      @(posedge clk); #1 dcache_read = 1'b0; dcache_write = 1'b0;
      check("rw_wr_cycles", 128'(wr_cycles), 128'(2));
      check("rw_rd_cycles", 128'(rd_cycles), 128'(0));

      // contested streak: D,D,D,I,D,D,D,I,D,D,D (leaves streak at 3)
      chk_en = 1'b0;
      dk = 0;
      for (int i = 0; i < 11; i++) begin
         if (pat[i]) begin
            push(1'b1, 16'h4000 + 16'(dk) * 16'h10);
            dk++;
         end else begin
            push(1'b0, 16'h2000);
         end
      end
      dk = 0;
      @(posedge clk); #1
      icache_read = 1'b1; icache_address = 16'h2000;
      dcache_read = 1'b1; dcache_address = 16'h4000;
      for (int n = 0; n < 11; n++) begin
         wait_resp(20, side);
         @(posedge clk); #1;
         if (n == 10) begin
            icache_read = 1'b0;
            dcache_read = 1'b0;
         end else if (side) begin
            dk++;
            dcache_address = 16'h4000 + 16'(dk) * 16'h10;
         end
      end

      // reset in the middle of an uncontested D write
      chk_en = 1'b1; exp_addr = 16'h7000; exp_wdata = PAT_A5; mem_lat = 50;
      @(posedge clk); #1 dcache_write = 1'b1; dcache_address = 16'h7000; dcache_wdata = PAT_A5;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_mid_pmem_write", 128'(pmem_write), 128'(0));
      check("rst_mid_pmem_read", 128'(pmem_read), 128'(0));
      check("rst_mid_arb_busy", 128'(arb_busy), 128'(0));
      dcache_write = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      mem_lat = 2; chk_en = 1'b0;

      // streak cleared by reset: contested request goes to D first, then I
      push(1'b1, 16'h6000);
      push(1'b0, 16'h2100);
      @(posedge clk); #1
      dcache_read = 1'b1; dcache_address = 16'h6000;
      icache_read = 1'b1; icache_address = 16'h2100;
      wait_resp(20, side);
      @(posedge clk); #1 dcache_read = 1'b0;
      wait_resp(20, side);
      @(posedge clk); #1 icache_read = 1'b0;

      repeat (5) @(negedge clk);
      check("sb_drained", 128'(sb.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_mem_arbiter.md
# pipeline_mem_arbiter

Arbiter and sequencer that lets the LC-3b pipeline's instruction cache and data cache share the single physical-memory line port. Requests are latched at grant and replayed to memory until it responds. Returned line data is held and presented to the granted cache with a one-cycle response pulse. Data-side requests have priority, and a bounded streak counter keeps instruction fetch from starving behind back-to-back data misses and writebacks. The block sits between the two caches and the physical memory model in the top-level datapath.

## Interface
- LINE_W, 128, cache line width in bits
- ADDR_W, 16, byte address width
- MAX_D_STREAK, 3, consecutive contested D grants allowed before I is forced (1..7)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- icache_read  in  1  I-side line fill request
- icache_address  in  ADDR_W  I-side line address
- icache_resp  out  1  one-cycle I-side completion pulse
- icache_rdata  out  LINE_W  I-side fill data, valid while icache_resp=1
- dcache_read  in  1  D-side line fill request
- dcache_write  in  1  D-side line writeback request
- dcache_address  in  ADDR_W  D-side line address
- dcache_wdata  in  LINE_W  D-side writeback data
- dcache_resp  out  1  one-cycle D-side completion pulse
- dcache_rdata  out  LINE_W  D-side fill data, valid while dcache_resp=1
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  latched request address
- pmem_wdata  out  LINE_W  latched writeback data
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion
- arb_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE. Registers: state, owner (0=I, 1=D), op_write, addr_q, wdata_q, line_q, d_streak (3-bit).
- IDLE: a D request is dcache_read|dcache_write; an I request is icache_read.
  - D only: grant D.
  - I only: grant I.
  - Both requesting: grant I if d_streak==MAX_D_STREAK, otherwise grant D.
- On grant, latch address, op_write and owner; for a D write, also latch dcache_wdata into wdata_q.
- If dcache_read and dcache_write are both high, the request is treated as a write.
- d_streak update:
  - D granted while I also requesting: d_streak+1, saturating at MAX_D_STREAK.
  - Any I grant: d_streak=0.
  - Uncontested D grant: d_streak unchanged.
- SERVE_I/SERVE_D:
  - pmem_read=!op_write and pmem_write=op_write, driven continuously from state.
  - pmem_address=addr_q, pmem_wdata=wdata_q; these stay stable for the whole transfer.
  - On pmem_resp: capture pmem_rdata into line_q and go to DONE.
- DONE:
  - Assert owner's resp for exactly one cycle; that side's rdata=line_q.
  - The other side's resp is 0; both rdata outputs always show line_q.
  - Next state is IDLE unconditionally.
- Requester rule: a cache drops its request in the cycle after its resp. The IDLE cycle after DONE therefore never re-grants a completed request.
- pmem_resp is ignored in IDLE and DONE.

## Timing
- Reset (async, immediate):
  - state=IDLE, d_streak=0, addr_q/wdata_q/line_q=0.
  - All resp, pmem strobes and arb_busy are 0.
  - A transfer in flight is abandoned; strobes drop at reset assertion, not at the next edge.
- Request high in IDLE cycle c leads to a grant at the edge ending c. Strobes are high from c+1.
- pmem_resp in cycle c+k (k≥1) leads to resp in cycle c+k+1, then IDLE in c+k+2.
- Minimum request-to-resp latency is 2 cycles. Back-to-back transactions are spaced by at least 3 cycles (IDLE, SERVE, DONE).
- Request inputs are sampled only in IDLE; changes during SERVE/DONE have no effect.
- The memory must hold pmem_resp for one cycle per transfer. If it is held high for more cycles, only the first counts, because the state has already left SERVE.

## Test plan
- I-only fill, memory responds 3 cycles after pmem_read:
  - pmem_read high 3 cycles with pmem_address=icache_address.
  - icache_resp high exactly 1 cycle with icache_rdata=pmem_rdata; dcache_resp stays 0.
- D writeback, dcache_wdata=0xA5A5…A5, then changed mid-transfer:
  - pmem_write held with pmem_wdata=0xA5A5…A5 throughout.
  - dcache_resp pulses once; pmem_read never asserts.
- I and D both requesting continuously with MAX_D_STREAK=3:
  - Grant order is D,D,D,I,D,D,D,I.
  - d_streak returns to 0 after each I grant.
- dcache_read and dcache_write both high: the transfer is a write (pmem_write=1, pmem_read=0).
- rst_n asserted low in the middle of a SERVE_D transfer:
  - pmem_write drops in the same cycle; arb_busy=0.
  - After release, a new I request is granted normally with d_streak=0.
- pmem_resp pulsed while IDLE with no requests: no resp output, state stays IDLE.
